spi_shift_engine: RTL and testbench

SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_edge_detect.sv | 25 ++
 rtl/spi_shift_engine.sv | 125 ++++++++++++
 tb/tb_spi_shift_engine.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift engine: controller states and the
// serial clock period produced by the external divider stage.
package spi_pkg;

    // Number of system clock cycles per divided serial clock period.
    localparam int unsigned SCLK_PERIOD = 32;

    // Transfer controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_edge_detect.sv
// Rising/falling edge detector for a slow signal that is already synchronous
// to clk. The delayed copy clears on reset so no edge appears at reset exit.
module spi_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;

    // Keep last cycle's value of the input for edge comparison.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/spi_shift_engine.sv
// SPI mode 0 master shift engine. An external divider supplies sclk_in; this
// block holds that divider in reset outside a transfer so every transfer
// starts with the serial clock low and the divider counter at zero. Data is
// shifted MSB first: miso is captured on serial clock rises, the transmit
// register advances on falls so mosi is stable around every rise.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              sclk_in,
    input  logic              miso,
    output logic              clk_devider_reset,
    output logic              spi_sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);

    spi_state_e        state_q, state_d;
    logic [DATA_W-1:0] txShift_q, txShift_d;
    logic [DATA_W-1:0] rxShift_q, rxShift_d;
    logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
    logic [DATA_W-1:0] rxData_q, rxData_d;

    logic inXfer;
    logic sclkGated;
    logic sclkRise;
    logic sclkFall;

    assign inXfer = (state_q == XFER);

    // The serial clock is only passed through during a transfer; feeding the
    // gated version to the edge detector guarantees its delayed copy is low
    // on the first XFER cycle.
    assign sclkGated = inXfer & sclk_in;

    spi_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (sclkGated),
        .rise  (sclkRise),
        .fall  (sclkFall)
    );

    // Register all controller state; reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            txShift_q <= '0;
            rxShift_q <= '0;
            bitCnt_q  <= '0;
            rxData_q  <= '0;
        end else begin
            state_q   <= state_d;
            txShift_q <= txShift_d;
            rxShift_q <= rxShift_d;
            bitCnt_q  <= bitCnt_d;
            rxData_q  <= rxData_d;
        end
    end

    // Next-state and datapath: load on start, sample on rise, shift or finish
    // on fall. rx_data is updated on the way into DONE so it is already valid
    // while done is high.
    always_comb begin
        state_d   = state_q;
        txShift_d = txShift_q;
        rxShift_d = rxShift_q;
        bitCnt_d  = bitCnt_q;
        rxData_d  = rxData_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    txShift_d = tx_data;
                    rxShift_d = '0;
                    bitCnt_d  = '0;
                    state_d   = XFER;
                end
            end

            XFER: begin
                if (sclkRise) begin
                    rxShift_d = {rxShift_q[DATA_W-2:0], miso};
                    bitCnt_d  = bitCnt_q + CNT_W'(1);
                end
                if (sclkFall) begin
                    if (bitCnt_q < LAST_BIT) begin
                        txShift_d = {txShift_q[DATA_W-2:0], 1'b0};
                    end else begin
                        rxData_d = rxShift_q;
                        state_d  = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign clk_devider_reset = ~inXfer;
    assign spi_sclk          = sclkGated;
    assign mosi              = txShift_q[DATA_W-1];
    assign cs_n              = ~inXfer;
    assign busy              = (state_q != IDLE);
    assign done              = (state_q == DONE);
    assign rx_data           = rxData_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Scoreboard bench for spi_shift_engine with a behavioural divider and a
// selectable slave (loopback, tied high, or shift-register slave).
module tb_spi_shift_engine;

    localparam int DATA_W  = 8;
    localparam int LATENCY = 258;

    typedef struct {
        logic [7:0] expRx;
        logic [7:0] expTx;
        int         startCycle;
    } sbEntry_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] tx_data;
    logic       sclk_in;
    logic       miso;
    logic       clk_devider_reset;
    logic       spi_sclk;
    logic       mosi;
    logic       cs_n;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;
    int doneCount = 0;

    sbEntry_t sbQ[$];
    sbEntry_t curEntry;

    logic [4:0] divCnt = 5'd0;
    int         misoMode = 0;
    logic [7:0] slaveWord = 8'h00;
    logic [7:0] slaveShift = 8'h00;

    logic       sclkPrevTb = 1'b0;
    logic       csPrevTb = 1'b1;
    int         riseCount = 0;
    logic [7:0] mosiByte = 8'h00;
    logic       mosiSeenHigh = 1'b0;
    int         firstCsLow = -1;
    int         lastCsLow = -1;

    spi_shift_engine #(.DATA_W(DATA_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .tx_data           (tx_data),
        .sclk_in           (sclk_in),
        .miso              (miso),
        .clk_devider_reset (clk_devider_reset),
        .spi_sclk          (spi_sclk),
        .mosi              (mosi),
        .cs_n              (cs_n),
        .busy              (busy),
        .done              (done),
        .rx_data           (rx_data)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency and chip-select window checks.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Behavioural clock divider, held at zero while the engine requests it.
    always @(posedge clk) begin
        if (clk_devider_reset) divCnt <= 5'd0;
        else                   divCnt <= divCnt + 5'd1;
    end
    assign sclk_in = (int'(divCnt) >= int'(spi_pkg::SCLK_PERIOD / 2));

    assign miso = (misoMode == 0) ? mosi :
                  (misoMode == 1) ? 1'b1 : slaveShift[7];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, actual, expected, cycleCount);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one start pulse; optionally queue the expected completion.
    task automatic applyStimulus(input logic [7:0] tx, input logic [7:0] expRx,
                                 input bit pushIt);
        start   = 1'b1;
        tx_data = tx;
        if (pushIt) sbQ.push_back('{expRx, tx, cycleCount});
        stepCycles(1);
        start = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles);
        int n = 0;
        while (sbQ.size() != 0 && n < maxCycles) begin
            stepCycles(1);
            n++;
        end
        if (sbQ.size() != 0) begin
            checkOutput("doneTimeout", 32'(sbQ.size()), 32'd0);
            sbQ.delete();
        end
        stepCycles(3);
    endtask

    // Monitor: track serial activity, run the slave, score every done pulse.
    always @(negedge clk) begin
        if (!cs_n && csPrevTb) begin
            firstCsLow   = cycleCount;
            riseCount    = 0;
            mosiByte     = 8'h00;
            mosiSeenHigh = 1'b0;
        end
        if (!cs_n) begin
            lastCsLow = cycleCount;
            if (mosi) mosiSeenHigh = 1'b1;
        end
        if (spi_sclk && !sclkPrevTb) begin
            riseCount++;
            mosiByte = {mosiByte[6:0], mosi};
        end
        if (cs_n) slaveShift = slaveWord;
        else if (!spi_sclk && sclkPrevTb) slaveShift = {slaveShift[6:0], 1'b0};

        if (done) begin
            doneCount++;
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedDone", 32'd1, 32'd0);
            end else begin
                curEntry = sbQ.pop_front();
                checkOutput("rxData", 32'(rx_data), 32'(curEntry.expRx));
                checkOutput("doneLatency", 32'(cycleCount - curEntry.startCycle), 32'(LATENCY));
                checkOutput("csLowFirst", 32'(firstCsLow), 32'(curEntry.startCycle + 1));
                checkOutput("csLowLast", 32'(lastCsLow), 32'(curEntry.startCycle + LATENCY - 1));
                checkOutput("mosiAtRises", 32'(mosiByte), 32'(curEntry.expTx));
            end
        end
        sclkPrevTb = spi_sclk;
        csPrevTb   = cs_n;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        int doneBefore;
        reset   = 1'b1;
        start   = 1'b0;
        tx_data = 8'h00;
        stepCycles(3);

        checkOutput("resetCsN", 32'(cs_n), 32'd1);
        checkOutput("resetDivReset", 32'(clk_devider_reset), 32'd1);
        checkOutput("resetSclk", 32'(spi_sclk), 32'd0);
        checkOutput("resetMosi", 32'(mosi), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetRxData", 32'(rx_data), 32'd0);
        reset = 1'b0;
        stepCycles(4);

        $display("[TB] loopback 0xA5");
        misoMode = 0;
        applyStimulus(8'hA5, 8'hA5, 1'b1);
        waitIdle(400);
        checkOutput("rxDataHeld", 32'(rx_data), 32'h0A5);

        $display("[TB] miso tied high, tx 0x00");
        misoMode = 1;
        applyStimulus(8'h00, 8'hFF, 1'b1);
        waitIdle(400);
        checkOutput("mosiZeroThroughout", 32'(mosiSeenHigh), 32'd0);

        $display("[TB] slave returns 0x3C for tx 0xC3");
        misoMode  = 2;
        slaveWord = 8'h3C;
        stepCycles(2);
        applyStimulus(8'hC3, 8'h3C, 1'b1);
        waitIdle(400);
        checkOutput("slaveRxHeld", 32'(rx_data), 32'h03C);

        $display("[TB] start held high with changing tx_data");
        misoMode = 0;
        start    = 1'b1;
        tx_data  = 8'h5A;
        sbQ.push_back('{8'h5A, 8'h5A, cycleCount});
        sbQ.push_back('{8'h81, 8'h81, cycleCount + LATENCY + 1});
        stepCycles(100);
        tx_data = 8'h81;
        stepCycles(160);
        start   = 1'b0;
        tx_data = 8'hFF;
        waitIdle(400);
        checkOutput("noThirdTransfer", 32'(busy), 32'd0);

        $display("[TB] reset after third rise");
        applyStimulus(8'hA5, 8'h00, 1'b0);
        stepCycles(2);
        guard = 0;
        while (riseCount < 3 && guard < 400) begin
            stepCycles(1);
            guard++;
        end
        checkOutput("thirdRiseSeen", 32'(riseCount >= 3), 32'd1);
        checkOutput("sclkHighBeforeReset", 32'(spi_sclk), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("abortCsN", 32'(cs_n), 32'd1);
        checkOutput("abortDivReset", 32'(clk_devider_reset), 32'd1);
        checkOutput("abortSclk", 32'(spi_sclk), 32'd0);
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortRxData", 32'(rx_data), 32'd0);
        doneBefore = doneCount;
        stepCycles(2);
        reset = 1'b0;
        stepCycles(300);
        checkOutput("abortNoDone", 32'(doneCount - doneBefore), 32'd0);

        $display("[TB] recovery transfer 0x96");
        applyStimulus(8'h96, 8'h96, 1'b1);
        waitIdle(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
